// File: rtl/jam_gen_if.sv
// Bus bundle for jam_gen: search handshake, cost-table lookup and result outputs.
// The slave modport is the search engine; the master modport is whoever
// issues searches and serves the combinational cost table.
interface jam_gen_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int SUMW = CW + IDXW;

  logic                 start;
  logic                 mode;
  logic [IDXW-1:0]      W;
  logic [IDXW-1:0]      J;
  logic [CW-1:0]        Cost;
  logic                 busy;
  logic                 Valid;
  logic [SUMW-1:0]      BestCost;
  logic [MCW-1:0]       MatchCount;
  logic [N*IDXW-1:0]    BestPerm;

  modport master (
    output start, mode, Cost,
    input  W, J, busy, Valid, BestCost, MatchCount, BestPerm
  );

  modport slave (
    input  start, mode, Cost,
    output W, J, busy, Valid, BestCost, MatchCount, BestPerm
  );
endinterface

// File: rtl/jam_gen.sv
// Exhaustive assignment-problem search: walks every worker-to-job permutation
// in lexicographic order (next-permutation algorithm, one step per cycle),
// sums the looked-up costs and keeps the best total, its multiplicity and the
// first permutation that achieved it.
module jam_gen #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) (
  input logic      CLK,
  input logic      RST,
  jam_gen_if.slave bus
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int SUMW = CW + IDXW;

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);
  localparam logic [IDXW-1:0] PIV_START = IDXW'((N > 1) ? N - 2 : 0);
  localparam logic [IDXW-1:0] IDX_ZERO  = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EVAL    = 3'd1;
  localparam logic [2:0] S_CMP     = 3'd2;
  localparam logic [2:0] S_PIVOT   = 3'd3;
  localparam logic [2:0] S_SUCC    = 3'd4;
  localparam logic [2:0] S_SWAP    = 3'd5;
  localparam logic [2:0] S_REVERSE = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  function automatic logic [N*IDXW-1:0] ident_perm();
    logic [N*IDXW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*IDXW +: IDXW] = IDXW'(k);
    return r;
  endfunction

  logic [2:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               mode_q, mode_d;
  logic               first_q, first_d;
  logic [IDXW-1:0]    w_q, w_d;
  logic [IDXW-1:0]    j_q, j_d;
  logic [IDXW-1:0]    piv_q, piv_d;
  logic [IDXW-1:0]    succ_q, succ_d;
  logic [IDXW-1:0]    lo_q, lo_d;
  logic [IDXW-1:0]    hi_q, hi_d;
  logic [SUMW-1:0]    sum_q, sum_d;
  logic [SUMW-1:0]    best_cost_q, best_cost_d;
  logic [MCW-1:0]     match_cnt_q, match_cnt_d;
  logic [N*IDXW-1:0]  best_perm_q, best_perm_d;
  logic [IDXW-1:0]    perm_q [N];
  logic [IDXW-1:0]    perm_d [N];
  logic [N*IDXW-1:0]  perm_packed_s;
  logic               better_s;

  // Flatten the working permutation into the BestPerm layout.
  always_comb begin
    perm_packed_s = '0;
    for (int k = 0; k < N; k++) perm_packed_s[k*IDXW +: IDXW] = perm_q[k];
  end

  // Next-state, permutation stepping and best-result update.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    mode_d      = mode_q;
    first_d     = first_q;
    piv_d       = piv_q;
    succ_d      = succ_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    best_cost_d = best_cost_q;
    match_cnt_d = match_cnt_q;
    best_perm_d = best_perm_q;
    w_d         = IDX_ZERO;
    j_d         = IDX_ZERO;
    for (int k = 0; k < N; k++) perm_d[k] = perm_q[k];
    better_s = mode_q ? (sum_q > best_cost_q) : (sum_q < best_cost_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          first_d = 1'b1;
          for (int k = 0; k < N; k++) perm_d[k] = IDXW'(k);
          state_d = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        sum_d = sum_q + SUMW'(bus.Cost);
        if (w_q == LAST_IDX) state_d = S_CMP;
        else                 state_d = S_EVAL;
      end
      S_CMP: begin
        // The first permutation seeds the result; later ones compete with it.
        if (first_q || better_s) begin
          best_cost_d = sum_q;
          match_cnt_d = MCW'(1);
          best_perm_d = perm_packed_s;
        end else if (sum_q == best_cost_q) begin
          match_cnt_d = match_cnt_q + MCW'(1);
        end else begin
          match_cnt_d = match_cnt_q;
        end
        first_d = 1'b0;
        piv_d   = PIV_START;
        if (N < 2) state_d = S_DONE;
        else       state_d = S_PIVOT;
      end
      S_PIVOT: begin
        // Rightmost ascent marks the pivot; none means the last permutation.
        if (perm_q[piv_q] < perm_q[piv_q + IDX_ONE]) begin
          succ_d  = LAST_IDX;
          state_d = S_SUCC;
        end else if (piv_q == IDX_ZERO) begin
          state_d = S_DONE;
        end else begin
          piv_d = piv_q - IDX_ONE;
        end
      end
      S_SUCC: begin
        // A successor always exists once a pivot was found; the zero guard
        // only keeps the FSM out of a runaway scan.
        if (perm_q[succ_q] > perm_q[piv_q]) begin
          state_d = S_SWAP;
        end else if (succ_q == IDX_ZERO) begin
          state_d = S_DONE;
        end else begin
          succ_d = succ_q - IDX_ONE;
        end
      end
      S_SWAP: begin
        perm_d[piv_q]  = perm_q[succ_q];
        perm_d[succ_q] = perm_q[piv_q];
        lo_d = piv_q + IDX_ONE;
        hi_d = LAST_IDX;
        if ((piv_q + IDX_ONE) < LAST_IDX) state_d = S_REVERSE;
        else                              state_d = S_EVAL;
      end
      S_REVERSE: begin
        perm_d[lo_q] = perm_q[hi_q];
        perm_d[hi_q] = perm_q[lo_q];
        lo_d = lo_q + IDX_ONE;
        hi_d = hi_q - IDX_ONE;
        if ((lo_q + IDX_ONE) < (hi_q - IDX_ONE)) state_d = S_REVERSE;
        else                                     state_d = S_EVAL;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Lookup indices are registered: present them for the cycle they are used,
    // taking J from the permutation as it will stand after this edge.
    if (state_d == S_EVAL) begin
      if (state_q == S_EVAL) begin
        w_d = w_q + IDX_ONE;
      end else begin
        w_d   = IDX_ZERO;
        sum_d = '0;
      end
      j_d = perm_d[w_d];
    end else begin
      w_d = IDX_ZERO;
      j_d = IDX_ZERO;
    end
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      w_q         <= '0;
      j_q         <= '0;
      piv_q       <= '0;
      succ_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      best_cost_q <= '0;
      match_cnt_q <= '0;
      best_perm_q <= ident_perm();
      for (int k = 0; k < N; k++) perm_q[k] <= IDXW'(k);
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      w_q         <= w_d;
      j_q         <= j_d;
      piv_q       <= piv_d;
      succ_q      <= succ_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      best_cost_q <= best_cost_d;
      match_cnt_q <= match_cnt_d;
      best_perm_q <= best_perm_d;
      for (int k = 0; k < N; k++) perm_q[k] <= perm_d[k];
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.BestCost   = best_cost_q;
  assign bus.MatchCount = match_cnt_q;
  assign bus.BestPerm   = best_perm_q;
endmodule

// File: doc/jam_gen.md
JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of workers and jobs (legal range 1..8).
REQ-002 The block SHALL have parameter CW, default 7, giving the Cost width in bits.
REQ-003 The block SHALL have parameter MCW, default 16, giving the MatchCount width (MCW bits must hold N!).
REQ-004 The block SHALL use the derived widths IDXW = max(1, clog2(N)) and SUMW = CW + IDXW.
REQ-005 The block SHALL have port CLK, input, 1 bit, the clock; all logic is rising-edge only.
REQ-006 The block SHALL have port RST, input, 1 bit, the reset; reset RST, asynchronous, active-high; clock CLK.
REQ-007 The block SHALL have port start, input, 1 bit, a single-cycle request to begin a search.
REQ-008 The block SHALL have port mode, input, 1 bit, the search goal: 0 = minimum-cost, 1 = maximum-cost.
REQ-009 The block SHALL have port W, output, IDXW bits, the worker index of the cost lookup.
REQ-010 The block SHALL have port J, output, IDXW bits, the job index of the cost lookup.
REQ-011 The block SHALL have port Cost, input, CW bits, the cost of (W,J), supplied combinationally by the cost table.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a search is in progress.
REQ-013 The block SHALL have port Valid, output, 1 bit, high when the results are final.
REQ-014 The block SHALL have port BestCost, output, SUMW bits, the best total cost found.
REQ-015 The block SHALL have port MatchCount, output, MCW bits, the number of permutations achieving BestCost.
REQ-016 The block SHALL have port BestPerm, output, N*IDXW bits, the first best permutation; worker w's job is in bits [w*IDXW +: IDXW].

Function
REQ-017 The block SHALL enumerate all N! worker-to-job permutations in lexicographic order, starting from the identity permutation.
REQ-018 The FSM SHALL use the states IDLE, EVAL, CMP, PIVOT, SUCC, SWAP, REVERSE and DONE.
REQ-019 In IDLE, start=1 SHALL latch mode, reset the permutation to identity, set busy=1, clear Valid, and go to EVAL.
REQ-020 In EVAL, W SHALL step 0..N-1, one index per cycle, with J = perm[W]; Cost SHALL be sampled at the edge ending each cycle and accumulated into a SUMW-bit sum, so EVAL lasts exactly N cycles.
REQ-021 In CMP, for the first permutation of a search, the block SHALL load BestCost = sum, MatchCount = 1 and BestPerm = perm unconditionally.
REQ-022 In CMP for later permutations, a strictly better sum (less than BestCost for mode 0, greater for mode 1) SHALL load BestCost and BestPerm and set MatchCount = 1.
REQ-023 In CMP for later permutations, a sum equal to BestCost SHALL increment MatchCount and leave BestPerm unchanged.
REQ-024 PIVOT SHALL scan i from N-2 down, one index per cycle, for the first perm[i] < perm[i+1]; if none is found, the FSM SHALL go to DONE.
REQ-025 SUCC SHALL scan j from N-1 down, one index per cycle, for the first perm[j] > perm[i].
REQ-026 SWAP SHALL exchange perm[i] and perm[j] in 1 cycle.
REQ-027 REVERSE SHALL reverse perm[i+1..N-1] with two converging pointers, one pair per cycle, then go to EVAL; an empty or single-element suffix SHALL skip straight to EVAL.
REQ-028 In DONE, the block SHALL set Valid=1 and busy=0 and return to IDLE; Valid and all results SHALL hold until the next accepted start.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 mode changes SHALL be ignored while busy=1.
REQ-031 For N=1, the block SHALL evaluate the single permutation, then reach DONE with MatchCount = 1.
REQ-032 The cost sum SHALL never overflow, since N*(2^CW-1) fits in SUMW bits.
REQ-033 W and J SHALL be registered and held at 0 outside EVAL.

Reset
REQ-034 RST=1 SHALL asynchronously force the FSM to IDLE, busy=0, Valid=0, W=0, J=0, BestCost=0, MatchCount=0, BestPerm=identity, and the internal sum to 0.
REQ-035 Reset asserted mid-search SHALL abandon that search; no partial result SHALL appear on Valid.
REQ-036 After reset is released, the block SHALL wait for a new start.

Verification
REQ-037 The bench SHALL cover: N=3, Cost(w,j)=w+j, mode 0 -> Valid=1, BestCost=6, MatchCount=6, BestPerm={0,1,2}.
REQ-038 The bench SHALL cover: N=4, Cost=0 on the diagonal and 10 elsewhere, mode 0 -> BestCost=0, MatchCount=1, BestPerm={0,1,2,3}; then mode 1 -> BestCost=40, MatchCount=9, BestPerm={1,0,3,2}.
REQ-039 The bench SHALL cover: N=8, CW=7, all costs 127 -> BestCost=1016, MatchCount=40320, with exactly 8 EVAL cycles per permutation.
REQ-040 The bench SHALL cover: RST pulsed during EVAL of the 5th permutation -> outputs return to reset values, then a fresh start reproduces the REQ-037 results.
REQ-041 The bench SHALL cover: start and mode toggled while busy -> results are unchanged versus an undisturbed run; N=1 with Cost=5 -> BestCost=5, MatchCount=1.
